// File: rtl/param_register_file.sv
// Parametrised register file for the 16-bit datapath: two registered read
// ports, one write port, optional write-through bypass and a status register
// carrying Z/C flags (top two bits) and an interrupt-enable bit (bit 0).
module param_register_file #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int FLAG_REG = 2,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              flag_upd,
  input  logic [DATA_W:0]   alu_result,
  output logic              flag_z,
  output logic              flag_c,
  output logic              ien
);

  // One extra bit so NUM_REGS == 2**ADDR_W is representable in the compare.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_err_q, wr_err_d;

  logic wr_ok, rd_a_ok, rd_b_ok;

  assign wr_ok   = {1'b0, wr_addr}   < NUM_REGS_W;
  assign rd_a_ok = {1'b0, rd_addr_a} < NUM_REGS_W;
  assign rd_b_ok = {1'b0, rd_addr_b} < NUM_REGS_W;

  // Next register contents: data write first, then flag update overrides Z/C
  // so a same-cycle write to the status register keeps the ALU flags.
  always_comb begin
    // NOTE: every combinational output starts from a default so no path
    // through the block leaves it unassigned, which would infer a latch.
    mem_d = mem_q;
    if (wr_en && wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
    if (flag_upd) begin
      mem_d[FLAG_REG][DATA_W-1] = (alu_result[DATA_W-1:0] == '0);
      mem_d[FLAG_REG][DATA_W-2] = alu_result[DATA_W];
    end
  end

  // Read-port next state: bypass reads the post-update view, otherwise the
  // pre-write contents; out-of-range addresses read as zero.
  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    rd_valid_d  = rd_en;
    wr_err_d    = wr_en && !wr_ok;
    if (rd_en) begin
      rd_data_a_d = '0;
      rd_data_b_d = '0;
      if (rd_a_ok) begin
        rd_data_a_d = (BYPASS != 0) ? mem_d[rd_addr_a] : mem_q[rd_addr_a];
      end
      if (rd_b_ok) begin
        rd_data_b_d = (BYPASS != 0) ? mem_d[rd_addr_b] : mem_q[rd_addr_b];
      end
    end
  end

  // State registers with synchronous reset overriding all strobes.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the register array is reset element by element because the
      // datapath relies on all registers (including flags) reading zero.
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_valid_q  <= rd_valid_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;
  assign wr_err    = wr_err_q;

  assign flag_z = mem_q[FLAG_REG][DATA_W-1];
  assign flag_c = mem_q[FLAG_REG][DATA_W-2];
  assign ien    = mem_q[FLAG_REG][0];

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file. Three instances share one stimulus:
// default (BYPASS=1, 8 regs), BYPASS=0, and NUM_REGS=5. Inputs change on the
// falling edge; outputs are compared on the following falling edge.
module tb_param_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        flag_upd;
  logic [16:0] alu_result;

  logic [15:0] a1, b1, a0, b0, a5, b5;
  logic        v1, v0, v5, e1, e0, e5;
  logic        z1, c1, i1, z0, c0, i0, z5, c5, i5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_register_file dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(a1), .rd_data_b(b1), .rd_valid(v1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(e1), .flag_upd(flag_upd), .alu_result(alu_result),
    .flag_z(z1), .flag_c(c1), .ien(i1)
  );

  param_register_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(a0), .rd_data_b(b0), .rd_valid(v0), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(e0), .flag_upd(flag_upd), .alu_result(alu_result),
    .flag_z(z0), .flag_c(c0), .ien(i0)
  );

  param_register_file #(.NUM_REGS(5)) dut5 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(a5), .rd_data_b(b5), .rd_valid(v5), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(e5), .flag_upd(flag_upd), .alu_result(alu_result),
    .flag_z(z5), .flag_c(c5), .ien(i5)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; flag_upd = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; wr_data = '0; alu_result = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; rd_en = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h1111;
    cyc();
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", v1); end
    checks++; if ({z1, c1, i1} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {z1, c1, i1}); end
    idle();
    rd_en = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd2;
    cyc();
    checks++; if (a1 !== 16'h0000) begin errors++; $display("FAIL reset_rd_a: got %h want 0000", a1); end
    checks++; if (b1 !== 16'h0000) begin errors++; $display("FAIL reset_rd_b: got %h want 0000", b1); end
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL reset_rd_valid: got %b want 1", v1); end
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b want 0", e1); end
    idle();
    cyc();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0007;
    cyc();
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL wr_no_valid: got %b want 0", v1); end
    idle();
    rd_en = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd1;
    cyc();
    checks++; if (a1 !== 16'h0007) begin errors++; $display("FAIL wr_rd_a: got %h want 0007", a1); end
    checks++; if (b1 !== 16'h0007) begin errors++; $display("FAIL wr_rd_b: got %h want 0007", b1); end
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL wr_rd_valid: got %b want 1", v1); end
    idle();
    cyc();
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b want 0", v1); end
    checks++; if (a1 !== 16'h0007) begin errors++; $display("FAIL rd_hold: got %h want 0007", a1); end
    // Back-to-back reads with different addresses; reg0 is an ordinary register.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hA5A5;
    cyc();
    idle();
    rd_en = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd1;
    cyc();
    checks++; if ({a1, b1} !== {16'hA5A5, 16'h0007}) begin errors++; $display("FAIL b2b_first: got %h %h want a5a5 0007", a1, b1); end
    rd_addr_a = 3'd1; rd_addr_b = 3'd0;
    cyc();
    checks++; if ({a1, b1, v1} !== {16'h0007, 16'hA5A5, 1'b1}) begin errors++; $display("FAIL b2b_second: got %h %h %b want 0007 a5a5 1", a1, b1, v1); end
    idle();
    cyc();
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
    rd_en = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd1;
    cyc();
    checks++; if (a1 !== 16'hBEEF) begin errors++; $display("FAIL bypass1_a: got %h want beef", a1); end
    checks++; if (a0 !== 16'h0000) begin errors++; $display("FAIL bypass0_a: got %h want 0000", a0); end
    checks++; if (b1 !== 16'h0007) begin errors++; $display("FAIL bypass1_b_other: got %h want 0007", b1); end
    idle();
    rd_en = 1'b1; rd_addr_a = 3'd3;
    cyc();
    checks++; if (a0 !== 16'hBEEF) begin errors++; $display("FAIL bypass0_later: got %h want beef", a0); end
    // Both ports on the written address.
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h1234;
    rd_addr_a = 3'd4; rd_addr_b = 3'd4;
    cyc();
    checks++; if ({a1, b1} !== {16'h1234, 16'h1234}) begin errors++; $display("FAIL bypass1_both: got %h %h want 1234 1234", a1, b1); end
    checks++; if ({a0, b0} !== {16'h0000, 16'h0000}) begin errors++; $display("FAIL bypass0_both: got %h %h want 0000 0000", a0, b0); end
    idle();
    cyc();
  endtask

  task automatic test_flags();
    flag_upd = 1'b1; alu_result = 17'h10000;
    rd_en = 1'b1; rd_addr_a = 3'd2;
    cyc();
    checks++; if ({z1, c1, i1} !== 3'b110) begin errors++; $display("FAIL flags_zc: got %b want 110", {z1, c1, i1}); end
    checks++; if (a1 !== 16'hC000) begin errors++; $display("FAIL flag_bypass1: got %h want c000", a1); end
    checks++; if (a0 !== 16'h0000) begin errors++; $display("FAIL flag_bypass0: got %h want 0000", a0); end
    alu_result = 17'h00005;
    cyc();
    checks++; if ({z1, c1, i1} !== 3'b000) begin errors++; $display("FAIL flags_clear: got %b want 000", {z1, c1, i1}); end
    checks++; if ({a1, a0} !== {16'h0000, 16'hC000}) begin errors++; $display("FAIL flag_bypass_clear: got %h %h want 0000 c000", a1, a0); end
    idle();
    cyc();
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0001;
    flag_upd = 1'b1; alu_result = 17'h00000;
    rd_en = 1'b1; rd_addr_b = 3'd2;
    cyc();
    checks++; if ({z1, c1, i1} !== 3'b101) begin errors++; $display("FAIL collide_flags: got %b want 101", {z1, c1, i1}); end
    checks++; if (b1 !== 16'h8001) begin errors++; $display("FAIL collide_bypass1: got %h want 8001", b1); end
    checks++; if (b0 !== 16'h0000) begin errors++; $display("FAIL collide_bypass0: got %h want 0000", b0); end
    idle();
    rd_en = 1'b1; rd_addr_b = 3'd2;
    cyc();
    checks++; if ({b1, b0} !== {16'h8001, 16'h8001}) begin errors++; $display("FAIL collide_reg: got %h %h want 8001 8001", b1, b0); end
    // A plain write to the status register sets every bit from wr_data.
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h4000; rd_en = 1'b0;
    cyc();
    checks++; if ({z1, c1, i1} !== 3'b010) begin errors++; $display("FAIL flag_write: got %b want 010", {z1, c1, i1}); end
    idle();
    cyc();
  endtask

  task automatic test_out_of_range();
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'hFFFF;
    cyc();
    checks++; if (e5 !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b want 1", e5); end
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL inrange_wr_err: got %b want 0", e1); end
    wr_addr = 3'd5; wr_data = 16'hEEEE;
    cyc();
    checks++; if (e5 !== 1'b1) begin errors++; $display("FAIL oor_boundary_err: got %b want 1", e5); end
    idle();
    cyc();
    checks++; if (e5 !== 1'b0) begin errors++; $display("FAIL wr_err_pulse: got %b want 0", e5); end
    rd_en = 1'b1; rd_addr_a = 3'd6; rd_addr_b = 3'd4;
    cyc();
    checks++; if ({a5, b5} !== {16'h0000, 16'h1234}) begin errors++; $display("FAIL oor_read: got %h %h want 0000 1234", a5, b5); end
    checks++; if (a1 !== 16'hFFFF) begin errors++; $display("FAIL reg6_8regs: got %h want ffff", a1); end
    rd_addr_a = 3'd1; rd_addr_b = 3'd3;
    cyc();
    checks++; if ({a5, b5} !== {16'h0007, 16'hBEEF}) begin errors++; $display("FAIL oor_unchanged: got %h %h want 0007 beef", a5, b5); end
    idle();
    cyc();
  endtask

  task automatic test_reset_mid();
    rd_en = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd3;
    cyc();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h5555;
    flag_upd = 1'b1; alu_result = 17'h10000;
    cyc();
    checks++; if ({a1, b1, v1} !== {16'h0000, 16'h0000, 1'b0}) begin errors++; $display("FAIL rst_mid_rd: got %h %h %b want 0000 0000 0", a1, b1, v1); end
    checks++; if ({z1, c1, i1, z5, c5, i5} !== 6'b0) begin errors++; $display("FAIL rst_mid_flags: got %b want 000000", {z1, c1, i1, z5, c5, i5}); end
    checks++; if ({e1, e5} !== 2'b00) begin errors++; $display("FAIL rst_mid_err: got %b want 00", {e1, e5}); end
    idle();
    rd_en = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd7;
    cyc();
    checks++; if ({a1, b1, a5} !== {16'h0000, 16'h0000, 16'h0000}) begin errors++; $display("FAIL rst_mid_regs: got %h %h %h want 0000 0000 0000", a1, b1, a5); end
    idle();
    cyc();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_flags();
    test_collision();
    test_out_of_range();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
